// File: rtl/ufm_burst_read_responder.sv
// ---------------------------------------------------------------------------
// ufm_burst_read_responder
//
// Burst read slave sitting in front of a synchronous backing ROM. A read
// command is captured while idle, the master is stalled for WAIT_CYCLES
// cycles, the command is then accepted for one cycle, and 1..3 beats are
// fetched from the ROM on consecutive cycles with a wrapping word address.
// ROM data returns one cycle after the strobe and is registered once more
// before it is presented, so every beat shows up two cycles after it was
// issued.
//
// Ports
//   clk                single clock, rising edge
//   reset_n            asynchronous active-low reset
//   ufm_addr_i         burst start word address
//   ufm_read_i         read request (held by the master while stalled)
//   ufm_burst_count_i  requested beats, 0 is treated as 1
//   ufm_wait_req_o     stall; low only in the single accept cycle
//   ufm_valid_o        one pulse per returned beat
//   ufm_data_o         returned beat, holds between pulses
//   rom_addr_o         ROM word address, holds between strobes
//   rom_rd_o           ROM read strobe
//   rom_data_i         ROM data, valid the cycle after rom_rd_o
//   busy_o             high whenever a command is in flight
// ---------------------------------------------------------------------------
module ufm_burst_read_responder #(
  parameter int  NUM_WORDS   = 512,
  parameter int  WAIT_CYCLES = 3,
  localparam int ADDR_W      = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ufm_addr_i,
  input  logic              ufm_read_i,
  input  logic [1:0]        ufm_burst_count_i,
  output logic              ufm_wait_req_o,
  output logic              ufm_valid_o,
  output logic [31:0]       ufm_data_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_rd_o,
  input  logic [31:0]       rom_data_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCEPT,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        beats_q;
  logic [3:0]        stall_q;
  logic [1:0]        remain_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              rd_d1_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN only ever lasts one cycle: the last beat was
  // strobed in the cycle before DRAIN, so the edge leaving DRAIN is the one
  // that puts the final valid pulse on the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ufm_read_i) begin
          state_d = (WAIT_CYCLES == 0) ? ST_ACCEPT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stall_q <= 4'd1) begin
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        state_d = (beats_q > 2'd1) ? ST_ISSUE : ST_DRAIN;
      end
      ST_ISSUE: begin
        if (remain_q == 2'd1) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and ROM strobe are decoded straight from the state. In ACCEPT
  // the captured start address goes out directly; afterwards rom_addr_q
  // carries the current beat address and simply holds once the burst ends.
  always_comb begin
    ufm_wait_req_o = (state_q != ST_ACCEPT);
    busy_o         = (state_q != ST_IDLE);
    rom_rd_o       = (state_q == ST_ACCEPT) || (state_q == ST_ISSUE);
    rom_addr_o     = (state_q == ST_ACCEPT) ? addr_q : rom_addr_q;
  end

  // Command capture, stall countdown and beat bookkeeping. Address and
  // count are sampled only on the capture edge so later input changes
  // cannot disturb a burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      beats_q    <= '0;
      stall_q    <= '0;
      remain_q   <= '0;
      rom_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ufm_read_i) begin
            addr_q  <= ufm_addr_i;
            beats_q <= (ufm_burst_count_i == 2'd0) ? 2'd1 : ufm_burst_count_i;
            stall_q <= 4'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          stall_q <= stall_q - 4'd1;
        end
        ST_ACCEPT: begin
          remain_q   <= beats_q - 2'd1;
          rom_addr_q <= (beats_q > 2'd1) ? addr_q + ADDR_W'(1) : addr_q;
        end
        ST_ISSUE: begin
          remain_q <= remain_q - 2'd1;
          if (remain_q != 2'd1) begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Return path: the strobe is delayed two stages to line up with the ROM
  // data that was registered one stage after it came back. The data
  // register only loads on a returning beat so it holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d1_q     <= 1'b0;
      ufm_valid_o <= 1'b0;
      ufm_data_o  <= '0;
    end else begin
      rd_d1_q     <= rom_rd_o;
      ufm_valid_o <= rd_d1_q;
      if (rd_d1_q) begin
        ufm_data_o <= rom_data_i;
      end
    end
  end

endmodule

// File: tb/tb_ufm_burst_read_responder.sv
// ---------------------------------------------------------------------------
// tb_ufm_burst_read_responder
//
// Drives two responders (WAIT_CYCLES=3 and WAIT_CYCLES=0), each with its own
// ROM model, from one shared command stream; sel picks which one is active.
// Every command's expected behaviour is laid out as a timeline relative to
// the capture edge (accept cycle, strobe window, return window, busy end)
// and each output is compared on every falling edge of that timeline.
// ---------------------------------------------------------------------------
module tb_ufm_burst_read_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        read_in = 1'b0;
  logic [8:0]  addr_in = '0;
  logic [1:0]  cnt_in = '0;

  logic        read3, read0;
  logic        wait3, valid3, rd3, busy3;
  logic [31:0] data3;
  logic [8:0]  raddr3;
  logic [31:0] rom_data3 = '0;
  logic        wait0, valid0, rd0, busy0;
  logic [31:0] data0;
  logic [8:0]  raddr0;
  logic [31:0] rom_data0 = '0;

  logic        obs_wait, obs_valid, obs_rd, obs_busy;
  logic [31:0] obs_data;
  logic [8:0]  obs_raddr;

  int          vec_cnt = 0;
  int          err_cnt = 0;

  logic [8:0]  prev_last [2];
  logic [31:0] prev_data [2];

  always #5 clk = ~clk;

  assign read3 = read_in & ~sel;
  assign read0 = read_in & sel;

  ufm_burst_read_responder #(.NUM_WORDS(512), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .ufm_addr_i(addr_in), .ufm_read_i(read3), .ufm_burst_count_i(cnt_in),
    .ufm_wait_req_o(wait3), .ufm_valid_o(valid3), .ufm_data_o(data3),
    .rom_addr_o(raddr3), .rom_rd_o(rd3), .rom_data_i(rom_data3),
    .busy_o(busy3)
  );

  ufm_burst_read_responder #(.NUM_WORDS(512), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .ufm_addr_i(addr_in), .ufm_read_i(read0), .ufm_burst_count_i(cnt_in),
    .ufm_wait_req_o(wait0), .ufm_valid_o(valid0), .ufm_data_o(data0),
    .rom_addr_o(raddr0), .rom_rd_o(rd0), .rom_data_i(rom_data0),
    .busy_o(busy0)
  );

  function automatic logic [31:0] rom_word(input logic [8:0] a);
    return {16'hA5A5, 7'h0, a};
  endfunction

  // Synchronous ROM models: data follows the strobe by one cycle.
  always @(posedge clk) begin
    if (rd3) rom_data3 <= rom_word(raddr3);
    if (rd0) rom_data0 <= rom_word(raddr0);
  end

  always_comb begin
    obs_wait  = sel ? wait0  : wait3;
    obs_valid = sel ? valid0 : valid3;
    obs_rd    = sel ? rd0    : rd3;
    obs_busy  = sel ? busy0  : busy3;
    obs_data  = sel ? data0  : data3;
    obs_raddr = sel ? raddr0 : raddr3;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, " valid"}, 32'(obs_valid), 32'd0);
    checkOutput({tag, " data"},  obs_data,       32'd0);
    checkOutput({tag, " rd"},    32'(obs_rd),    32'd0);
    checkOutput({tag, " raddr"}, 32'(obs_raddr), 32'd0);
    checkOutput({tag, " busy"},  32'(obs_busy),  32'd0);
    checkOutput({tag, " wait"},  32'(obs_wait),  32'd1);
  endtask

  // Issues one command at the current falling edge and checks the whole
  // timeline. With hold set the read stays high and the next command's
  // address/count are presented in the first idle cycle, so the caller
  // continues the chain with another call at that same edge.
  task automatic applyStimulus(input logic [8:0] a, input logic [1:0] cnt,
                               input bit hold, input logic [8:0] na,
                               input logic [1:0] ncnt);
    int          n, acc, last_c, k;
    logic [31:0] e_wait, e_rd, e_valid, e_busy, e_data;
    logic [8:0]  e_ra;
    n      = (cnt == 2'd0) ? 1 : int'(cnt);
    acc    = (sel ? 0 : 3) + 1;
    last_c = hold ? acc + n + 1 : acc + n + 3;
    k      = sel ? 1 : 0;
    read_in = 1'b1;
    addr_in = a;
    cnt_in  = cnt;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      e_wait  = (c != acc) ? 32'd1 : 32'd0;
      e_rd    = (c >= acc && c < acc + n) ? 32'd1 : 32'd0;
      e_valid = (c >= acc + 2 && c < acc + 2 + n) ? 32'd1 : 32'd0;
      e_busy  = (c < acc + n + 1) ? 32'd1 : 32'd0;
      if (e_rd != 0)      e_ra = a + 9'(c - acc);
      else if (c < acc)   e_ra = prev_last[k];
      else                e_ra = a + 9'(n - 1);
      if (e_valid != 0)     e_data = rom_word(a + 9'(c - acc - 2));
      else if (c < acc + 2) e_data = prev_data[k];
      else                  e_data = rom_word(a + 9'(n - 1));
      checkOutput("wait_req", 32'(obs_wait),  e_wait);
      checkOutput("rom_rd",   32'(obs_rd),    e_rd);
      checkOutput("rom_addr", 32'(obs_raddr), 32'(e_ra));
      checkOutput("valid",    32'(obs_valid), e_valid);
      checkOutput("data",     obs_data,       e_data);
      checkOutput("busy",     32'(obs_busy),  e_busy);
      if (c == 1) begin
        addr_in = 9'($urandom);
        cnt_in  = 2'($urandom);
        read_in = hold;
      end
      if (hold && c == last_c) begin
        addr_in = na;
        cnt_in  = ncnt;
      end
    end
    prev_last[k] = a + 9'(n - 1);
    prev_data[k] = rom_word(a + 9'(n - 1));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] cur_a, na;
    logic [1:0] cur_c, nc;
    bit         hold;
    prev_last[0] = '0; prev_last[1] = '0;
    prev_data[0] = '0; prev_data[1] = '0;

    // Reset state, then idle after release with no read.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleReset("reset");
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkIdleReset("post_reset");
    end
    sel = 1'b1;
    #1 checkIdleReset("post_reset_w0");
    sel = 1'b0;

    // Directed commands on the WAIT_CYCLES=3 responder.
    applyStimulus(9'h010, 2'd1, 1'b0, 9'h000, 2'd0);
    applyStimulus(9'h020, 2'd3, 1'b0, 9'h000, 2'd0);
    applyStimulus(9'h1FF, 2'd2, 1'b0, 9'h000, 2'd0);
    applyStimulus(9'h005, 2'd0, 1'b1, 9'h0AA, 2'd2);
    applyStimulus(9'h0AA, 2'd2, 1'b1, 9'h0AB, 2'd1);
    applyStimulus(9'h0AB, 2'd1, 1'b0, 9'h000, 2'd0);

    // Reset in the middle of a 3-beat burst (second ISSUE cycle).
    read_in = 1'b1; addr_in = 9'h040; cnt_in = 2'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) read_in = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1 checkIdleReset("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkIdleReset("after_abort");
    end
    prev_last[0] = '0; prev_last[1] = '0;
    prev_data[0] = '0; prev_data[1] = '0;
    applyStimulus(9'h033, 2'd1, 1'b0, 9'h000, 2'd0);

    // Random commands, some chained with the read held high.
    cur_a = 9'($urandom); cur_c = 2'($urandom);
    for (int i = 0; i < 40; i++) begin
      na   = 9'($urandom);
      nc   = 2'($urandom);
      hold = ($urandom_range(0, 2) == 0);
      applyStimulus(cur_a, cur_c, hold, na, nc);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      cur_a = na; cur_c = nc;
    end
    if (read_in) begin
      repeat (8) @(negedge clk);
    end

    // WAIT_CYCLES=0 responder: finish any chain on the other DUT first.
    read_in = 1'b0;
    repeat (8) @(negedge clk);
    sel = 1'b1;
    applyStimulus(9'h1FE, 2'd3, 1'b1, 9'h100, 2'd0);
    applyStimulus(9'h100, 2'd0, 1'b0, 9'h000, 2'd0);
    cur_a = 9'($urandom); cur_c = 2'($urandom);
    for (int i = 0; i < 15; i++) begin
      na   = 9'($urandom);
      nc   = 2'($urandom);
      hold = ($urandom_range(0, 2) == 0);
      if (i == 14) hold = 1'b0;
      applyStimulus(cur_a, cur_c, hold, na, nc);
      cur_a = na; cur_c = nc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ufm_burst_read_responder.md
UFM_BURST_READ_RESPONDER -- requirements
Module: ufm_burst_read_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 512, UFM word count; power of two, minimum 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 3, stall cycles inserted before command accept; range 0..15.
REQ-003 SHALL derive ADDR_W = $clog2(NUM_WORDS) as a localparam.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ufm_addr_i  input  ADDR_W  burst start word address from the read master.
REQ-007 ufm_read_i  input  1  read request from the master, held while ufm_wait_req_o=1.
REQ-008 ufm_burst_count_i  input  2  beats requested; value 0 is treated as 1.
REQ-009 ufm_wait_req_o  output  1  stall; the command is accepted only in a cycle with ufm_read_i=1 and ufm_wait_req_o=0.
REQ-010 ufm_valid_o  output  1  read data valid, one pulse per beat.
REQ-011 ufm_data_o  output  32  read data beat.
REQ-012 rom_addr_o  output  ADDR_W  backing ROM word address.
REQ-013 rom_rd_o  output  1  backing ROM read strobe; data returns on rom_data_i one cycle later.
REQ-014 rom_data_i  input  32  backing ROM read data.
REQ-015 busy_o  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT, ACCEPT, ISSUE and DRAIN.
REQ-017 ufm_wait_req_o SHALL be combinational: 0 only in ACCEPT, 1 in all other states including IDLE.
REQ-018 IDLE, edge with ufm_read_i=1: latch address into addr_q and beat count into beats_q (0 becomes 1), load stall counter with WAIT_CYCLES, then go to WAIT, or to ACCEPT if WAIT_CYCLES=0.
REQ-019 WAIT: decrement the stall counter each edge; on the edge where it reaches 0, go to ACCEPT.
REQ-020 ACCEPT: lasts exactly one cycle; rom_rd_o=1 and rom_addr_o=addr_q (beat 0); next state is ISSUE if beats_q>1, else DRAIN.
REQ-021 ISSUE: rom_rd_o=1 on consecutive cycles, one beat per cycle; the address increments by 1 per beat, modulo NUM_WORDS (NUM_WORDS-1 wraps to 0); go to DRAIN after the last beat is issued.
REQ-022 Data path: rom_rd_o is delayed 2 cycles to form ufm_valid_o; ufm_data_o is registered from rom_data_i. The beat issued in cycle k therefore appears with ufm_valid_o=1 in cycle k+2.
REQ-023 Beats SHALL be returned in address order, with no gaps, exactly beats_q pulses per command.
REQ-024 DRAIN: on the edge that makes the last ufm_valid_o pulse visible, go to IDLE.
REQ-025 ufm_read_i SHALL be ignored outside IDLE. A read held across the return to IDLE is captured as a new command.
REQ-026 ufm_addr_i and ufm_burst_count_i changes after capture SHALL have no effect on the in-flight burst.
REQ-027 ufm_data_o SHALL hold its last value when ufm_valid_o=0.
REQ-028 rom_addr_o SHALL hold its last value when rom_rd_o=0.

Reset
REQ-029 Reset assertion SHALL immediately set state=IDLE, ufm_valid_o=0, ufm_data_o=0, rom_rd_o=0, rom_addr_o=0, busy_o=0, and clear all counters and the delay pipeline.
REQ-030 Reset mid-burst SHALL discard all pending beats; no ufm_valid_o pulse may follow release until a new command is accepted.
REQ-031 Outputs SHALL equal their reset values from the first edge after reset release until a read is captured.

Verification
REQ-032 Bench model: ROM word[a] = {16'hA5A5, 7'h0, a[8:0]}; WAIT_CYCLES=3.
REQ-033 Single beat, addr 0x010, count 1: ufm_wait_req_o=0 exactly 4 cycles after the capture edge; 1 valid beat of 0xA5A50010 two cycles after ACCEPT; busy_o then drops.
REQ-034 Burst, addr 0x020, count 3: 3 consecutive valid beats 0xA5A50020, 0xA5A50021, 0xA5A50022; rom_rd_o high exactly 3 cycles.
REQ-035 Wrap, addr 0x1FF, count 2: beats 0xA5A501FF then 0xA5A50000.
REQ-036 Count 0, addr 0x005: exactly one beat 0xA5A50005. Back-to-back reads held high: second command captured only after the return to IDLE, with no beat loss or duplication.
REQ-037 Reset pulse during ISSUE of a 3-beat burst: outputs cleared asynchronously, zero valid beats after release; the next 1-beat read completes normally.
REQ-038 WAIT_CYCLES=0 build: ACCEPT is entered on the edge after capture; data timing is otherwise unchanged.
